tpu_sequencer: RTL and testbench
================================

Name: tpu_sequencer

Overview:
Instruction-driven controller that sequences the 2x2 TPU datapath: weight load, input load, matmul compute, accumulator drain and store.
- A host pushes short instructions into a small internal FIFO.
- The block decodes them and drives load_weight, load_input, valid, store and base_address toward the weight memory, unified buffer, systolic array and accumulators.
- It sits between the host/testbench and the datapath, and monitors the accumulator full flags to know when a matmul has completed.

Parameters:
ADDR_W, 13, width of base_address and instr_addr
FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2)
VALID_CYCLES, 4, cycles valid is held high per MMUL
DRAIN_TIMEOUT, 16, max cycles to wait for both accumulators full before flagging error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  pulse: enter RUN mode and clear err
instr_valid  in  1  host instruction push request
instr_ready  out  1  FIFO can accept; push occurs when instr_valid & instr_ready
instr_op  in  3  opcode: 0 NOP, 1 LDW, 2 LDI, 3 MMUL, 4 STORE, 5 HALT, 6-7 illegal
instr_addr  in  ADDR_W  operand address
acc1_full  in  1  accumulator 1 full
acc2_full  in  1  accumulator 2 full
load_weight  out  1  weight load strobe
load_input  out  1  unified-buffer input load strobe
valid  out  1  systolic array/accumulator valid
store  out  1  unified-buffer store strobe
base_address  out  ADDR_W  address for current instruction
busy  out  1  high while RUN and (state != IDLE or FIFO non-empty)
done  out  1  one-cycle pulse on HALT retirement
err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async):
  - FIFO flushed, running=0, state=IDLE.
  - All outputs 0 except instr_ready=1.
  - Reset mid-instruction aborts it immediately; no strobe is completed.
- Outputs are Moore: driven from flops only, no combinational path from any input to any output.
  - Exception: instr_ready = !fifo_full, itself a flop-derived signal.
- FIFO:
  - Push when instr_valid & instr_ready.
  - When full, instr_ready=0 even if a pop happens that cycle.
  - No bypass: an entry pushed in cycle N is poppable no earlier than cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- start:
  - Sets running=1 and clears err.
  - Ignored while already running, except that err is still cleared.
- FSM states: IDLE, LDW, LDI, COMPUTE, DRAIN, STORE, HALTED.
- IDLE:
  - If running and FIFO non-empty, pop the head into cur_op/cur_addr and go to the op's state on the next cycle.
  - NOP: stays IDLE (1 cycle consumed).
  - Illegal op: sets err, stays IDLE.
  - HALT: go to HALTED.
- LDW: load_weight=1, base_address=cur_addr for exactly 1 cycle, then IDLE.
- LDI: load_input=1, base_address=cur_addr for 1 cycle, then IDLE.
- COMPUTE:
  - valid=1 and base_address=cur_addr for exactly VALID_CYCLES cycles (down-counter), then DRAIN.
- DRAIN:
  - valid=0, base_address held.
  - seen1/seen2 latch acc1_full/acc2_full independently; both flags are sampled in COMPUTE as well.
  - When seen1 & seen2, go to IDLE.
  - If DRAIN_TIMEOUT cycles elapse first, set err and go to IDLE.
  - seen flags clear on DRAIN exit.
- STORE: store=1, base_address=cur_addr for 1 cycle, then IDLE.
- HALTED:
  - done=1 for that single cycle, running cleared, then IDLE.
  - Remaining FIFO entries are retained and execute after the next start.
- base_address:
  - Holds its last value while in IDLE.
  - Reset value 0.
- Strobe exclusivity: at most one of load_weight/load_input/valid/store is high in any cycle.
- Minimum back-to-back throughput: one strobe instruction per 2 cycles (IDLE + exec).

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds output mmul_count [15:0], reset 0.
  - Increments when DRAIN exits successfully.
  - Saturates at 16'hFFFF.
  - Timeouts do not count.
- Undefined: port and counter are absent; all other behaviour identical.

Test Plan:
- Reset then push LDW 0x010, LDI 0x020, STORE 0x030 before start -> no strobes; after start, load_weight@0x010, load_input@0x020, store@0x030, each exactly 1 cycle, separated by 1 IDLE cycle.
- MMUL 0x040 with acc1_full rising 2 cycles and acc2_full 5 cycles after COMPUTE entry -> valid high exactly 4 cycles, DRAIN exits the cycle after seen2, err=0, mmul_count=1 (macro on).
- MMUL with acc2_full never asserted -> err=1 after 16 DRAIN cycles, FSM returns IDLE, following STORE still executes; a subsequent start clears err.
- Push 5 instructions with FIFO_DEPTH=4 while not running -> instr_ready=0 after 4th push, 5th not accepted; after start, instr_ready returns 1 the cycle after the first pop.
- Push op 7 then HALT -> err=1, done pulses 1 cycle, busy=0, running=0; a queued LDW stays pending until the next start.
- Assert reset=0 during COMPUTE cycle 2 -> valid drops immediately, FIFO empty, instr_ready=1, all strobes 0.

Source files
------------

// File: rtl/tpu_sequencer_if.sv
// rtl/tpu_sequencer_if.sv - host instruction push and datapath strobe bundle for tpu_sequencer
// Optional SEQ_PERF_CNT_EN adds mmul_count.
interface tpu_sequencer_if #(
   parameter int ADDR_W = 13
);
   logic              start;
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        instr_op;
   logic [ADDR_W-1:0] instr_addr;
   logic              acc1_full;
   logic              acc2_full;
   logic              load_weight;
   logic              load_input;
   logic              valid;
   logic              store;
   logic [ADDR_W-1:0] base_address;
   logic              busy;
   logic              done;
   logic              err;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0]       mmul_count;

   modport master (
      output start, instr_valid, instr_op, instr_addr, acc1_full, acc2_full,
      input  instr_ready, load_weight, load_input, valid, store, base_address,
             busy, done, err, mmul_count
   );
   modport slave (
      input  start, instr_valid, instr_op, instr_addr, acc1_full, acc2_full,
      output instr_ready, load_weight, load_input, valid, store, base_address,
             busy, done, err, mmul_count
   );
`else
   modport master (
      output start, instr_valid, instr_op, instr_addr, acc1_full, acc2_full,
      input  instr_ready, load_weight, load_input, valid, store, base_address,
             busy, done, err
   );
   modport slave (
      input  start, instr_valid, instr_op, instr_addr, acc1_full, acc2_full,
      output instr_ready, load_weight, load_input, valid, store, base_address,
             busy, done, err
   );
`endif
endinterface

// File: rtl/tpu_sequencer.sv
// rtl/tpu_sequencer.sv - instruction FIFO and FSM sequencing the 2x2 TPU datapath
// Optional SEQ_PERF_CNT_EN adds a saturating count of successful MMUL drains.
module tpu_sequencer #(
   parameter int ADDR_W        = 13,
   parameter int FIFO_DEPTH    = 4,
   parameter int VALID_CYCLES  = 4,
   parameter int DRAIN_TIMEOUT = 16
) (
   input logic            clk,
   input logic            reset,
   tpu_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LDW     = 3'd1;
   localparam logic [2:0] S_LDI     = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_STORE   = 3'd5;
   localparam logic [2:0] S_HALTED  = 3'd6;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LDW   = 3'd1;
   localparam logic [2:0] OP_LDI   = 3'd2;
   localparam logic [2:0] OP_MMUL  = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_HALT  = 3'd5;

   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (VALID_CYCLES > DRAIN_TIMEOUT) ? VALID_CYCLES : DRAIN_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [PW:0]   PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] CNT_ZERO = 0;
   localparam logic [CW-1:0] VC_LAST  = CW'(VALID_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(DRAIN_TIMEOUT - 1);

   logic [2:0]        fifo_op   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              running_q, running_d, err_q, err_d;
   logic              seen1_q, seen1_d, seen2_q, seen2_d;
   logic              fifo_empty, fifo_full, push, pop;
   logic [2:0]        head_op;
   logic [ADDR_W-1:0] head_addr;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0]       mmul_q, mmul_d;
`endif

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push       = bus.instr_valid && !fifo_full;
   assign pop        = (state_q == S_IDLE) && running_q && !fifo_empty;
   assign head_op    = fifo_op[rd_ptr_q[PW-1:0]];
   assign head_addr  = fifo_addr[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr_q[PW-1:0]]   <= bus.instr_op;
         fifo_addr[wr_ptr_q[PW-1:0]] <= bus.instr_addr;
      end
   end

   always_comb begin
      wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      running_d = running_q;
      err_d     = err_q;
      seen1_d   = seen1_q;
      seen2_d   = seen2_q;
`ifdef SEQ_PERF_CNT_EN
      mmul_d    = mmul_q;
`endif
      if (bus.start) begin
         running_d = 1'b1;
         err_d     = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               case (head_op)
                  OP_NOP:   state_d = S_IDLE;
                  OP_LDW:   begin state_d = S_LDW;   base_d = head_addr; end
                  OP_LDI:   begin state_d = S_LDI;   base_d = head_addr; end
                  OP_MMUL:  begin state_d = S_COMPUTE; base_d = head_addr; cnt_d = VC_LAST; end
                  OP_STORE: begin state_d = S_STORE; base_d = head_addr; end
                  OP_HALT:  state_d = S_HALTED;
                  default:  err_d = 1'b1;
               endcase
            end
         end
         S_COMPUTE: begin
            seen1_d = seen1_q | bus.acc1_full;
            seen2_d = seen2_q | bus.acc2_full;
            if (cnt_q == CNT_ZERO) begin
               state_d = S_DRAIN;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DRAIN: begin
            if (seen1_q && seen2_q) begin
               state_d = S_IDLE;
               seen1_d = 1'b0;
               seen2_d = 1'b0;
`ifdef SEQ_PERF_CNT_EN
               if (mmul_q != 16'hFFFF) mmul_d = mmul_q + 16'd1;
`endif
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               seen1_d = 1'b0;
               seen2_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               seen1_d = seen1_q | bus.acc1_full;
               seen2_d = seen2_q | bus.acc2_full;
            end
         end
         // A start arriving while halting is ignored because running is still set.
         S_HALTED: begin
            running_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= S_IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         err_q     <= 1'b0;
         seen1_q   <= 1'b0;
         seen2_q   <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
         mmul_q    <= 16'd0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         state_q   <= state_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
         err_q     <= err_d;
         seen1_q   <= seen1_d;
         seen2_q   <= seen2_d;
`ifdef SEQ_PERF_CNT_EN
         mmul_q    <= mmul_d;
`endif
      end
   end

   assign bus.instr_ready  = !fifo_full;
   assign bus.load_weight  = (state_q == S_LDW);
   assign bus.load_input   = (state_q == S_LDI);
   assign bus.valid        = (state_q == S_COMPUTE);
   assign bus.store        = (state_q == S_STORE);
   assign bus.base_address = base_q;
   assign bus.busy         = running_q && ((state_q != S_IDLE) || !fifo_empty);
   assign bus.done         = (state_q == S_HALTED);
   assign bus.err          = err_q;
`ifdef SEQ_PERF_CNT_EN
   assign bus.mmul_count   = mmul_q;
`endif
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb/tb_tpu_sequencer.sv - directed self-checking bench for tpu_sequencer
module tb_tpu_sequencer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   tpu_sequencer_if #(.ADDR_W(13)) bus ();

   tpu_sequencer #(
      .ADDR_W(13), .FIFO_DEPTH(4), .VALID_CYCLES(4), .DRAIN_TIMEOUT(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] strb();
      return {28'd0, bus.load_weight, bus.load_input, bus.valid, bus.store};
   endfunction

   task automatic push(input logic [2:0] op, input logic [12:0] addr);
      bus.instr_valid = 1'b1;
      bus.instr_op    = op;
      bus.instr_addr  = addr;
      step();
      bus.instr_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr_op = 3'd0;
      bus.instr_addr = 13'd0;
      bus.acc1_full = 1'b0;
      bus.acc2_full = 1'b0;
      step();
      step();
      chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rst_strobes", strb(), 32'h0);
      chk("rst_base", {19'd0, bus.base_address}, 32'h0);
      chk("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'h0);
`ifdef SEQ_PERF_CNT_EN
      chk("rst_mmul_count", {16'd0, bus.mmul_count}, 32'd0);
`endif
      reset = 1'b1;
      step();

      // Queued before start: nothing executes.
      push(3'd1, 13'h010);
      push(3'd2, 13'h020);
      push(3'd4, 13'h030);
      step();
      step();
      chk("idle_no_strobe", strb(), 32'h0);
      chk("idle_not_busy", {31'd0, bus.busy}, 32'd0);
      pulse_start();
      chk("run_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("ldw_strobe", strb(), 32'h8);
      chk("ldw_addr", {19'd0, bus.base_address}, 32'h010);
      step();
      chk("gap1_strobe", strb(), 32'h0);
      chk("gap1_addr_held", {19'd0, bus.base_address}, 32'h010);
      step();
      chk("ldi_strobe", strb(), 32'h4);
      chk("ldi_addr", {19'd0, bus.base_address}, 32'h020);
      step();
      chk("gap2_strobe", strb(), 32'h0);
      step();
      chk("store_strobe", strb(), 32'h1);
      chk("store_addr", {19'd0, bus.base_address}, 32'h030);
      step();
      chk("seq_end_strobe", strb(), 32'h0);
      chk("seq_end_busy", {31'd0, bus.busy}, 32'd0);

      // MMUL with both accumulators filling.
      push(3'd3, 13'h040);
      step();
      chk("mm_c0_valid", strb(), 32'h2);
      chk("mm_c0_addr", {19'd0, bus.base_address}, 32'h040);
      step();
      chk("mm_c1_valid", strb(), 32'h2);
      step();
      chk("mm_c2_valid", strb(), 32'h2);
      bus.acc1_full = 1'b1;
      step();
      chk("mm_c3_valid", strb(), 32'h2);
      step();
      chk("mm_drain1_valid", strb(), 32'h0);
      chk("mm_drain1_addr", {19'd0, bus.base_address}, 32'h040);
      step();
      bus.acc2_full = 1'b1;
      step();
      chk("mm_drain3_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("mm_exit_busy", {31'd0, bus.busy}, 32'd0);
      chk("mm_exit_err", {31'd0, bus.err}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
      chk("mm_count", {16'd0, bus.mmul_count}, 32'd1);
`endif
      bus.acc1_full = 1'b0;
      bus.acc2_full = 1'b0;

      // MMUL timing out, then a STORE behind it.
      push(3'd3, 13'h050);
      push(3'd4, 13'h060);
      chk("to_c0_valid", strb(), 32'h2);
      for (int i = 0; i < 19; i++) step();
      chk("to_d16_valid", strb(), 32'h0);
      chk("to_d16_err", {31'd0, bus.err}, 32'd0);
      chk("to_d16_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("to_err_set", {31'd0, bus.err}, 32'd1);
      chk("to_idle_strobe", strb(), 32'h0);
      step();
      chk("to_store_strobe", strb(), 32'h1);
      chk("to_store_addr", {19'd0, bus.base_address}, 32'h060);
      step();
      pulse_start();
      chk("to_err_cleared", {31'd0, bus.err}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
      chk("to_count_unchanged", {16'd0, bus.mmul_count}, 32'd1);
`endif

      // Stop running, then overfill the FIFO.
      push(3'd5, 13'h000);
      step();
      chk("halt1_done", {31'd0, bus.done}, 32'd1);
      step();
      chk("halt1_done_clear", {31'd0, bus.done}, 32'd0);
      chk("halt1_not_busy", {31'd0, bus.busy}, 32'd0);
      push(3'd1, 13'h100);
      push(3'd2, 13'h101);
      push(3'd4, 13'h102);
      chk("ff_ready_3", {31'd0, bus.instr_ready}, 32'd1);
      push(3'd0, 13'h000);
      chk("ff_ready_full", {31'd0, bus.instr_ready}, 32'd0);
      push(3'd1, 13'h104);
      chk("ff_ready_still_full", {31'd0, bus.instr_ready}, 32'd0);
      pulse_start();
      chk("ff_ready_pre_pop", {31'd0, bus.instr_ready}, 32'd0);
      step();
      chk("ff_ready_after_pop", {31'd0, bus.instr_ready}, 32'd1);
      chk("ff_ldw_strobe", strb(), 32'h8);
      chk("ff_ldw_addr", {19'd0, bus.base_address}, 32'h100);
      step();
      step();
      chk("ff_ldi_strobe", strb(), 32'h4);
      chk("ff_ldi_addr", {19'd0, bus.base_address}, 32'h101);
      step();
      step();
      chk("ff_store_strobe", strb(), 32'h1);
      chk("ff_store_addr", {19'd0, bus.base_address}, 32'h102);
      step();
      step();
      chk("ff_nop_strobe", strb(), 32'h0);
      chk("ff_fifth_dropped", {31'd0, bus.busy}, 32'd0);

      // Illegal op, HALT, and a pending LDW.
      push(3'd7, 13'h1FF);
      push(3'd5, 13'h000);
      chk("ill_err", {31'd0, bus.err}, 32'd1);
      push(3'd1, 13'h200);
      chk("halt2_done", {31'd0, bus.done}, 32'd1);
      step();
      chk("halt2_done_clear", {31'd0, bus.done}, 32'd0);
      chk("halt2_not_busy", {31'd0, bus.busy}, 32'd0);
      chk("halt2_err_sticky", {31'd0, bus.err}, 32'd1);
      step();
      step();
      chk("halt2_ldw_pending", strb(), 32'h0);
      chk("halt2_base_held", {19'd0, bus.base_address}, 32'h102);
      pulse_start();
      chk("restart_err_clear", {31'd0, bus.err}, 32'd0);
      step();
      chk("restart_ldw_strobe", strb(), 32'h8);
      chk("restart_ldw_addr", {19'd0, bus.base_address}, 32'h200);
      step();

      // Reset in the second COMPUTE cycle with a STORE still queued.
      push(3'd3, 13'h300);
      push(3'd4, 13'h310);
      chk("rr_c0_valid", strb(), 32'h2);
      step();
      chk("rr_c1_valid", strb(), 32'h2);
      reset = 1'b0;
      #1;
      chk("rr_strobes", strb(), 32'h0);
      chk("rr_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rr_base", {19'd0, bus.base_address}, 32'h0);
      chk("rr_busy", {31'd0, bus.busy}, 32'd0);
      step();
      reset = 1'b1;
      step();
      pulse_start();
      step();
      step();
      chk("rr_fifo_flushed_busy", {31'd0, bus.busy}, 32'd0);
      chk("rr_fifo_flushed_strobe", strb(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
